stdp_synapse_array: RTL and testbench

Plastic synapse stage between the presynaptic LIF neurons and the postsynaptic LIF neuron. It holds one weight per presynaptic input and produces the postsynaptic input current as the saturating sum of the weights of the inputs that spiked. Weights are updated online with a pair-based STDP rule: pre-before-post potentiates, post-before-pre depresses. Consumes the pre spike vector and the post spike; its current_out drives the post neuron's current input.

---
 rtl/stdp_synapse_array.sv | 178 +++++++++++++++++
 tb/tb_stdp_synapse_array.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/stdp_synapse_array.sv
// -----------------------------------------------------------------------------
// stdp_synapse_array
//
// Plastic synapse stage between the presynaptic LIF neurons and the
// postsynaptic LIF neuron. Holds one 8-bit weight per presynaptic input and
// drives the post neuron with the saturating sum of the weights whose inputs
// spiked in the previous cycle. Weights learn online with a pair-based STDP
// rule: pre-before-post potentiates, post-before-pre depresses.
//
// Ports
//   clk          : clock, all logic on the rising edge
//   rst          : synchronous reset, active-high, highest priority
//   pre_spike    : presynaptic spikes, bit i = synapse i (1-cycle pulses)
//   post_spike   : postsynaptic spike (1-cycle pulse)
//   learn_en     : 1 = weight updates allowed, 0 = weights frozen
//   current_out  : registered saturating weighted spike sum
//   weights_flat : current weights, weight i at [8i+7:8i]
//   update_flag  : 1-cycle pulse when at least one weight changed value
//
// Optional build macro
//   STDP_WEIGHT_DECAY_EN : adds a 6-bit free-running counter; every 64 cycles
//                          each weight not hit by STDP steps 1 toward W_INIT.
// -----------------------------------------------------------------------------
module stdp_synapse_array #(
    parameter int N_SYN     = 5,
    parameter int W_INIT    = 64,
    parameter int W_MAX     = 255,
    parameter int W_MIN     = 0,
    parameter int TRACE_MAX = 15,
    parameter int DEP_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_SYN-1:0]   pre_spike,
    input  logic               post_spike,
    input  logic               learn_en,
    output logic [7:0]         current_out,
    output logic [8*N_SYN-1:0] weights_flat,
    output logic               update_flag
);

    localparam int         SUM_W = 8 + $clog2(N_SYN);
    localparam logic [3:0] TMAX  = 4'(TRACE_MAX);
    localparam logic [7:0] WINIT = 8'(W_INIT);
    localparam logic [7:0] WMAX  = 8'(W_MAX);
    localparam logic [7:0] WMIN  = 8'(W_MIN);

    logic [7:0]       w_q       [N_SYN];
    logic [7:0]       w_next    [N_SYN];
    logic [3:0]       t_pre_q   [N_SYN];
    logic [N_SYN-1:0] pre_seen_q;
    logic [3:0]       t_post_q;
    logic             post_seen_q;
    logic [7:0]       current_q;
    logic [7:0]       current_next;
    logic             flag_q;
    logic             changed;
    logic [SUM_W-1:0] spike_sum;
    logic [3:0]       dep_mag;

`ifdef STDP_WEIGHT_DECAY_EN
    logic [5:0] decay_cnt_q;
    logic       decay_tick;

    // The tick marks the cycle in which the counter wraps 63 -> 0.
    assign decay_tick = (decay_cnt_q == 6'd63);

    always_ff @(posedge clk) begin
        if (rst) begin
            decay_cnt_q <= 6'd0;
        end else begin
            decay_cnt_q <= decay_cnt_q + 6'd1;
        end
    end
`endif

    // Depression magnitude depends only on the shared post timer.
    assign dep_mag = (TMAX - t_post_q) >> DEP_SHIFT;

    always_comb begin
        logic [3:0]        gain;
        logic [8:0]        pot_sum;
        logic signed [8:0] dep_diff;
        logic              pot;
        logic              dep;

        changed   = 1'b0;
        spike_sum = '0;
        gain      = 4'd0;
        pot_sum   = 9'd0;
        dep_diff  = 9'sd0;
        pot       = 1'b0;
        dep       = 1'b0;

        for (int i = 0; i < N_SYN; i++) begin
            w_next[i] = w_q[i];

            // pot and dep are mutually exclusive: they need opposite
            // pre_spike[i] values. A same-cycle pre/post pair triggers neither.
            pot = post_spike & learn_en & pre_seen_q[i] & ~pre_spike[i];
            dep = pre_spike[i] & learn_en & post_seen_q & ~post_spike;

            gain     = TMAX - t_pre_q[i];
            pot_sum  = {1'b0, w_q[i]} + {5'b0, gain};
            dep_diff = $signed({1'b0, w_q[i]}) - $signed({5'b0, dep_mag});

            if (pot) begin
                w_next[i] = (pot_sum > {1'b0, WMAX}) ? WMAX : pot_sum[7:0];
            end else if (dep) begin
                w_next[i] = (dep_diff < $signed({1'b0, WMIN})) ? WMIN : dep_diff[7:0];
            end
`ifdef STDP_WEIGHT_DECAY_EN
            else if (decay_tick && learn_en) begin
                if (w_q[i] < WINIT) begin
                    w_next[i] = w_q[i] + 8'd1;
                end else if (w_q[i] > WINIT) begin
                    w_next[i] = w_q[i] - 8'd1;
                end
            end
`endif

            if (w_next[i] != w_q[i]) begin
                changed = 1'b1;
            end

            // Current uses the pre-update weight of this cycle.
            if (pre_spike[i]) begin
                spike_sum = spike_sum + {{(SUM_W-8){1'b0}}, w_q[i]};
            end
        end

        current_next = (spike_sum > {{(SUM_W-8){1'b0}}, 8'hFF}) ? 8'hFF : spike_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SYN; i++) begin
                w_q[i]     <= WINIT;
                t_pre_q[i] <= TMAX;
            end
            pre_seen_q  <= '0;
            t_post_q    <= TMAX;
            post_seen_q <= 1'b0;
            current_q   <= 8'd0;
            flag_q      <= 1'b0;
        end else begin
            for (int i = 0; i < N_SYN; i++) begin
                w_q[i] <= w_next[i];
                if (pre_spike[i]) begin
                    t_pre_q[i]    <= 4'd0;
                    pre_seen_q[i] <= 1'b1;
                end else if (t_pre_q[i] != TMAX) begin
                    t_pre_q[i]    <= t_pre_q[i] + 4'd1;
                    pre_seen_q[i] <= ((t_pre_q[i] + 4'd1) != TMAX);
                end
            end

            if (post_spike) begin
                t_post_q    <= 4'd0;
                post_seen_q <= 1'b1;
            end else if (t_post_q != TMAX) begin
                t_post_q    <= t_post_q + 4'd1;
                post_seen_q <= ((t_post_q + 4'd1) != TMAX);
            end

            current_q <= current_next;
            flag_q    <= changed;
        end
    end

    for (genvar g = 0; g < N_SYN; g++) begin : g_flat
        assign weights_flat[8*g +: 8] = w_q[g];
    end

    assign current_out = current_q;
    assign update_flag = flag_q;

endmodule

// File: tb/tb_stdp_synapse_array.sv
module tb_stdp_synapse_array;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  pre_spike;
    logic        post_spike;
    logic        learn_en;
    logic [7:0]  current_out;
    logic [39:0] weights_flat;
    logic        update_flag;

    int checks = 0;
    int errors = 0;

    stdp_synapse_array dut (
        .clk          (clk),
        .rst          (rst),
        .pre_spike    (pre_spike),
        .post_spike   (post_spike),
        .learn_en     (learn_en),
        .current_out  (current_out),
        .weights_flat (weights_flat),
        .update_flag  (update_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle with the given spikes; outputs are sampled 1 time unit
    // after the edge, so they reflect the update caused by this cycle.
    task automatic cyc(input logic [4:0] pre, input logic post);
        pre_spike  = pre;
        post_spike = post;
        @(posedge clk);
        #1;
        pre_spike  = 5'b0;
        post_spike = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(5'b0, 1'b0);
    endtask

    function automatic logic [31:0] wt(input int i);
        logic [7:0] v;
        v = weights_flat[8*i +: 8];
        return {24'b0, v};
    endfunction

    initial begin
        int exp_w;
        int prev_w;

        rst        = 1'b1;
        learn_en   = 1'b0;
        pre_spike  = 5'b0;
        post_spike = 1'b0;
        idle(2);
        rst = 1'b0;

        // Reset state
        for (int i = 0; i < 5; i++) chk($sformatf("reset_w%0d", i), wt(i), 32'd64);
        chk("reset_current", {24'b0, current_out}, 32'd0);
        chk("reset_flag", {31'b0, update_flag}, 32'd0);
        idle(20);
        for (int i = 0; i < 5; i++) chk($sformatf("idle_w%0d", i), wt(i), 32'd64);
        chk("idle_flag", {31'b0, update_flag}, 32'd0);

        // Potentiation: pre0, two idle cycles, post -> t_pre = 2, +13
        learn_en = 1'b1;
        cyc(5'b00001, 1'b0);
        chk("pot_pre_current", {24'b0, current_out}, 32'd64);
        chk("pot_pre_flag", {31'b0, update_flag}, 32'd0);
        idle(2);
        cyc(5'b00000, 1'b1);
        chk("pot_w0", wt(0), 32'd77);
        chk("pot_w1", wt(1), 32'd64);
        chk("pot_flag", {31'b0, update_flag}, 32'd1);
        idle(1);
        chk("pot_flag_pulse", {31'b0, update_flag}, 32'd0);
        idle(20);

        // Depression: post, three idle cycles, pre1 -> t_post = 3, -6
        cyc(5'b00000, 1'b1);
        chk("dep_post_flag", {31'b0, update_flag}, 32'd0);
        idle(3);
        cyc(5'b00010, 1'b0);
        chk("dep_w1", wt(1), 32'd58);
        chk("dep_flag", {31'b0, update_flag}, 32'd1);
        chk("dep_current_preupdate", {24'b0, current_out}, 32'd64);
        idle(20);

        // Current sums: w = {64,64,64,58,77} for synapses 4..0
        cyc(5'b00100, 1'b0);
        chk("cur_single", {24'b0, current_out}, 32'd64);
        cyc(5'b00011, 1'b0);
        chk("cur_pair", {24'b0, current_out}, 32'd135);
        cyc(5'b11111, 1'b0);
        chk("cur_saturate", {24'b0, current_out}, 32'd255);
        idle(1);
        chk("cur_idle", {24'b0, current_out}, 32'd0);
        idle(20);

        // Same-cycle pre3 and post: no change
        cyc(5'b01000, 1'b1);
        chk("dt0_w3", wt(3), 32'd64);
        chk("dt0_flag", {31'b0, update_flag}, 32'd0);
        idle(20);

        // Window expired: post 17 cycles after pre4 (t_pre would be 16)
        cyc(5'b10000, 1'b0);
        idle(16);
        cyc(5'b00000, 1'b1);
        chk("expired_w4", wt(4), 32'd64);
        chk("expired_flag", {31'b0, update_flag}, 32'd0);
        idle(20);

        // Last cycle of the window: t_pre = 14 -> +1
        cyc(5'b10000, 1'b0);
        idle(14);
        cyc(5'b00000, 1'b1);
        chk("edge_w4", wt(4), 32'd65);
        chk("edge_flag", {31'b0, update_flag}, 32'd1);
        idle(20);

        // Saturation: repeated pre2 -> post next cycle pairs (+15 each)
        exp_w = 64;
        for (int p = 0; p < 20; p++) begin
            cyc(5'b00100, 1'b0);
            cyc(5'b00000, 1'b1);
            prev_w = exp_w;
            exp_w  = (exp_w + 15 > 255) ? 255 : exp_w + 15;
            chk($sformatf("sat_w2_%0d", p), wt(2), exp_w);
            chk($sformatf("sat_flag_%0d", p), {31'b0, update_flag}, (exp_w != prev_w) ? 32'd1 : 32'd0);
            idle(16);
        end

        // Freeze: learn_en = 0 blocks both directions
        learn_en = 1'b0;
        cyc(5'b00001, 1'b0);
        cyc(5'b00000, 1'b1);
        chk("frz_pot_w0", wt(0), 32'd77);
        chk("frz_pot_flag", {31'b0, update_flag}, 32'd0);
        idle(2);
        cyc(5'b00001, 1'b0);
        chk("frz_dep_w0", wt(0), 32'd77);
        chk("frz_dep_flag", {31'b0, update_flag}, 32'd0);
        idle(20);

        // Reset mid-operation: pending pre trace is discarded
        learn_en = 1'b1;
        cyc(5'b00001, 1'b0);
        rst = 1'b1;
        cyc(5'b11111, 1'b0);
        rst = 1'b0;
        chk("rst_w0", wt(0), 32'd64);
        chk("rst_w2", wt(2), 32'd64);
        chk("rst_current", {24'b0, current_out}, 32'd0);
        chk("rst_flag", {31'b0, update_flag}, 32'd0);
        cyc(5'b00000, 1'b1);
        chk("rst_post_w0", wt(0), 32'd64);
        chk("rst_post_flag", {31'b0, update_flag}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
